// File: rtl/calc_bitserial_logic_seq.sv
// Bit-serial sequencer around a 1-bit gate unit.
// Operand bits go out LSB first, one pair per clock. The selected gate
// output is captured each cycle, and the assembled word is returned with
// a one-cycle done pulse.
module calc_bitserial_logic_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       sel,
  output logic             gate_in1,
  output logic             gate_in2,
  input  logic [7:0]       gate_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_sel;

  logic             w_last;
  logic             w_bit;
  logic [WIDTH-1:0] w_acc_next;

  assign w_last     = (r_cnt == LAST);
  assign w_bit      = gate_y[r_sel];
  assign w_acc_next = {w_bit, r_acc[WIDTH-1:1]};

  assign gate_in1 = (r_state == S_SHIFT) & r_a_sh[0];
  assign gate_in2 = (r_state == S_SHIFT) & r_b_sh[0];
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: accept in IDLE, WIDTH capture cycles, one DONE cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, shift/capture, result update.
  // result takes the final accumulator value on the edge that enters DONE,
  // so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_sel    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh <= op_a;
            r_b_sh <= op_b;
            r_sel  <= sel;
            r_cnt  <= '0;
            r_acc  <= '0;
          end
        end
        S_SHIFT: begin
          r_acc  <= w_acc_next;
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          if (w_last) r_result <= w_acc_next;
          else        r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/calc_bitserial_logic_seq.md
# calc_bitserial_logic_seq

Bit-serial sequencer that sits directly upstream and downstream of the calculator's 1-bit gate unit, which provides eight combinational outputs: AND, OR, XOR, NAND, NOR, XNOR, NOT in1, and in1. It accepts two WIDTH-bit operands and an operation select, then presents one operand bit pair per clock to the gate unit's inputs. Each cycle it captures the selected gate output, and after WIDTH cycles it returns the assembled WIDTH-bit result with a done pulse.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A, latched on accepted start
- op_b  input  WIDTH  operand B, latched on accepted start
- sel  input  3  operation select, latched on accepted start; 0..7 = AND, OR, XOR, NAND, NOR, XNOR, NOT A, pass A
- gate_in1  output  1  bit of A to gate unit in1
- gate_in2  output  1  bit of B to gate unit in2
- gate_y  input  8  gate unit outputs; bit0=y1 (AND) .. bit7=y8 (pass in1)
- busy  output  1  high while a request is in progress (state != IDLE)
- done  output  1  one-cycle pulse when result updates
- result  output  WIDTH  last completed result; holds until next completion

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches op_a and op_b into shift registers a_sh and b_sh, and sel into sel_q.
  - Clears bit counter and accumulator; next state is SHIFT.
- SHIFT:
  - gate_in1=a_sh[0] and gate_in2=b_sh[0], both driven from registers.
  - Each cycle: acc <= {gate_y[sel_q], acc[WIDTH-1:1]}; a_sh and b_sh shift right by 1; counter increments.
  - Bits go LSB first, so after WIDTH captures acc[i] = op(A[i], B[i]).
  - When counter reaches WIDTH-1 on a capture edge, next state is DONE.
- DONE (one cycle): result <= acc and done=1, then return to IDLE.
- gate_in1 and gate_in2 are 0 outside SHIFT.
- gate_y is treated as combinational from gate_in1/gate_in2 and sampled in the same cycle they are driven.
- start outside IDLE is ignored, including in the DONE cycle. Operands and sel changing after acceptance have no effect.
- result changes only on the DONE edge; intermediate acc values are never visible on result.
- Reset (asserted at any time, including mid-SHIFT) immediately forces:
  - state IDLE;
  - busy=0, done=0, result=0, gate_in1=0, gate_in2=0;
  - a_sh, b_sh, acc, counter, sel_q = 0.
- No partial result is kept after a reset.

## Timing
- Reset values: busy 0, done 0, result 0, gate_in1 0, gate_in2 0.
- Edge E0: start is sampled high in IDLE; busy goes high after E0.
- SHIFT occupies the WIDTH cycles after E0, with captures on edges E1..E_WIDTH.
- The DONE cycle follows edge E_WIDTH: done=1 and result is valid on the same edge.
- Latency: start-accept edge to done high = WIDTH+1 edges; accept-to-accept minimum = WIDTH+2 cycles.
- done is high for exactly one cycle per accepted start; busy is high during both SHIFT and DONE.
- Counter width is clog2(WIDTH) bits; no wrap beyond WIDTH-1.

## Test plan
- Reset then idle: hold rst_n=0 then release with start=0 -> busy=0, done=0, result=0, gate_in1/2=0 for 20 cycles.
- WIDTH=8, A=8'hC5, B=8'hA3, sel=0..7 in turn, with gate unit model attached:
  - results must be 81, E7, 66, 7E, 18, 99, 3A, C5 (hex) respectively;
  - done fires exactly 9 edges after each accept.
- Serial drive check, A=8'h01, B=8'h80:
  - gate_in1=1 only in the first SHIFT cycle;
  - gate_in2=1 only in the eighth;
  - sel=1 (OR) gives result 8'h81.
- Start while busy: accept A=8'hFF, B=8'h00, sel=0; pulse start with A=8'h55 during SHIFT and again during DONE -> result=8'h00, one done pulse, busy falls after DONE.
- Reset mid-operation: previous result 8'h66; start sel=1, A=8'hF0, B=8'h0F; drop rst_n at third SHIFT cycle -> result=0, busy=0, no done; next request completes normally with 8'hFF.
- Back-to-back: hold start=1 continuously with fixed operands -> accepts spaced exactly 10 cycles apart, done every 10 cycles, result stable between pulses.
